// File: rtl/gfg_reg_bank.sv
// Register bank behind an SPI slave: ID/CONTROL/STATUS plus shadow registers
// whose contents are copied to the active set only at a downstream safe point.
module gfg_reg_bank #(
  parameter int          NUM_REGISTERS  = 32,
  parameter int          REGISTER_WIDTH = 32,
  parameter logic [31:0] ID_VALUE       = 32'h0000_6F6B
) (
  input  logic                                      i_sys_clk,
  input  logic                                      i_arst_n,
  input  logic [$clog2(NUM_REGISTERS)-1:0]          i_reg_addr,
  input  logic [REGISTER_WIDTH-1:0]                 i_reg_write_data,
  input  logic                                      i_reg_write_en,
  output logic [REGISTER_WIDTH-1:0]                 o_reg_read_data,
  input  logic                                      i_commit_safe,
  output logic [(NUM_REGISTERS-3)*REGISTER_WIDTH-1:0] o_active_regs,
  output logic                                      o_commit_pulse,
  output logic                                      o_commit_pending,
  output logic                                      o_dbg_state
);

  typedef enum logic {IDLE = 1'b0, ARMED = 1'b1} state_t;

  // Reset asserts immediately and releases two clocks after i_arst_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge i_sys_clk or negedge i_arst_n) begin
    if (!i_arst_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_t                    state_q;
  logic                      auto_commit_q;
  logic [7:0]                write_count_q;
  logic [15:0]               ro_err_q;
  logic                      fire_q;
  logic                      pulse_q;
  logic [REGISTER_WIDTH-1:0] shadow_q [3:NUM_REGISTERS-1];
  logic [REGISTER_WIDTH-1:0] active_q [3:NUM_REGISTERS-1];

  logic [31:0] addr_ext;
  logic        wr_ctrl;
  logic        wr_shadow;
  logic        wr_ro;
  logic        pend_set;
  logic        fire;
  logic [31:0] status32;

  always_comb begin
    addr_ext  = 32'(i_reg_addr);
    wr_ctrl   = i_reg_write_en && (addr_ext == 32'd1);
    wr_shadow = i_reg_write_en && (addr_ext >= 32'd3) && (addr_ext < 32'(NUM_REGISTERS));
    wr_ro     = i_reg_write_en && !wr_ctrl && !wr_shadow;
    pend_set  = (wr_ctrl && i_reg_write_data[0]) || (wr_shadow && auto_commit_q);
    fire      = (state_q == ARMED) && i_commit_safe;
    status32  = {ro_err_q, write_count_q, 7'b0, state_q == ARMED};
  end

  always_ff @(posedge i_sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      auto_commit_q <= 1'b0;
      write_count_q <= 8'd0;
      ro_err_q      <= 16'd0;
      fire_q        <= 1'b0;
      pulse_q       <= 1'b0;
      for (int i = 3; i < NUM_REGISTERS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      // A pending-set landing on the commit cycle re-arms for the next safe point.
      if (fire)          state_q <= pend_set ? ARMED : IDLE;
      else if (pend_set) state_q <= ARMED;

      // Active takes the pre-write shadow when a write and a commit coincide.
      for (int i = 3; i < NUM_REGISTERS; i++) begin
        if (fire) active_q[i] <= shadow_q[i];
        if (wr_shadow && (addr_ext == 32'(i))) shadow_q[i] <= i_reg_write_data;
      end

      if (wr_ctrl) auto_commit_q <= i_reg_write_data[1];
      if (wr_ctrl || wr_shadow) write_count_q <= write_count_q + 8'd1;
      if (wr_ro && (ro_err_q != 16'hFFFF)) ro_err_q <= ro_err_q + 16'd1;

      fire_q  <= fire;
      pulse_q <= fire_q;
    end
  end

  // Zero-latency read path; the SPI slave samples one cycle after moving the address.
  always_comb begin
    o_reg_read_data = '0;
    if (addr_ext == 32'd0) begin
      o_reg_read_data = REGISTER_WIDTH'(ID_VALUE);
    end else if (addr_ext == 32'd1) begin
      o_reg_read_data[1] = auto_commit_q;
    end else if (addr_ext == 32'd2) begin
      o_reg_read_data = REGISTER_WIDTH'(status32);
    end else begin
      for (int i = 3; i < NUM_REGISTERS; i++) begin
        if (addr_ext == 32'(i)) o_reg_read_data = shadow_q[i];
      end
    end
  end

  always_comb begin
    o_active_regs = '0;
    for (int i = 3; i < NUM_REGISTERS; i++) begin
      o_active_regs[(i-3)*REGISTER_WIDTH +: REGISTER_WIDTH] = active_q[i];
    end
  end

  assign o_commit_pulse   = pulse_q;
  assign o_commit_pending = (state_q == ARMED);
  assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_gfg_reg_bank.sv
// Bench for gfg_reg_bank: directed vector table, hand-written corner sequences
// and random traffic, all checked against a behavioural register-map model.
module tb_gfg_reg_bank;

  localparam int N = 32;
  localparam int W = 32;
  localparam logic [31:0] ID = 32'h0000_6F6B;

  logic              clk = 1'b0;
  logic              arst_n;
  logic [4:0]        addr;
  logic [W-1:0]      wdata;
  logic              we;
  logic [W-1:0]      rdata;
  logic              safe;
  logic [(N-3)*W-1:0] active;
  logic              pulse;
  logic              pending;
  logic              dbg_state;

  gfg_reg_bank #(.NUM_REGISTERS(N), .REGISTER_WIDTH(W), .ID_VALUE(ID)) dut (
    .i_sys_clk       (clk),
    .i_arst_n        (arst_n),
    .i_reg_addr      (addr),
    .i_reg_write_data(wdata),
    .i_reg_write_en  (we),
    .o_reg_read_data (rdata),
    .i_commit_safe   (safe),
    .o_active_regs   (active),
    .o_commit_pulse  (pulse),
    .o_commit_pending(pending),
    .o_dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Behavioural model of the register map
  logic [31:0] m_shadow [N];
  logic [31:0] m_active [N];
  bit          m_auto;
  bit          m_pend;
  int          m_wc;
  int          m_err;
  bit          m_prev_fire;
  bit          m_pulse;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] act_reg(input int i);
    return active[(i-3)*W +: W];
  endfunction

  task automatic check_active(input string name);
    int bad_idx;
    bad_idx = -1;
    for (int i = 3; i < N; i++) begin
      if (bad_idx < 0 && act_reg(i) !== m_active[i]) bad_idx = i;
    end
    total++;
    if (bad_idx >= 0) begin
      bad++;
      $display("FAIL %s: active[%0d] got %h expected %h", name, bad_idx,
               act_reg(bad_idx), m_active[bad_idx]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_auto = 0; m_pend = 0; m_wc = 0; m_err = 0; m_prev_fire = 0; m_pulse = 0;
  endtask

  function automatic logic [31:0] model_read(input int a);
    logic [31:0] r;
    r = '0;
    if (a == 0)      r = ID;
    else if (a == 1) r = {30'b0, m_auto, 1'b0};
    else if (a == 2) r = {m_err[15:0], m_wc[7:0], 7'b0, m_pend};
    else if (a < N)  r = m_shadow[a];
    return r;
  endfunction

  task automatic model_step(input int a, input logic [31:0] d, input bit w, input bit s);
    bit fire, is_ctrl, is_sh, is_ro, set;
    fire    = m_pend && s;
    is_ctrl = w && a == 1;
    is_sh   = w && a >= 3 && a < N;
    is_ro   = w && !is_ctrl && !is_sh;
    set     = (is_ctrl && d[0]) || (is_sh && m_auto);
    if (fire) m_active = m_shadow;
    if (is_sh) m_shadow[a] = d;
    if (is_ctrl) m_auto = d[1];
    if (is_ctrl || is_sh) m_wc = (m_wc + 1) % 256;
    if (is_ro && m_err < 65535) m_err++;
    m_pend = set || (m_pend && !fire);
    m_pulse = m_prev_fire;
    m_prev_fire = fire;
  endtask

  // One clock: drive, check the combinational read, clock, check registered outputs.
  task automatic tick(input int a, input logic [31:0] d, input bit w, input bit s,
                      output logic [31:0] rd_pre);
    addr = 5'(a); wdata = d; we = w; safe = s;
    #1;
    rd_pre = rdata;
    check("read", rdata, model_read(a));
    @(posedge clk); #1;
    model_step(a, d, w, s);
    check("pending", {31'b0, pending}, {31'b0, m_pend});
    check("dbg_state", {31'b0, dbg_state}, {31'b0, m_pend});
    check("pulse", {31'b0, pulse}, {31'b0, m_pulse});
    check_active("active");
  endtask

  task automatic release_reset();
    we = 0; safe = 0;
    @(posedge clk); #1;
    arst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic        we;
    logic        safe;
    logic [31:0] exp_rd;
    logic        exp_pend;
    logic        exp_pulse;
    logic [31:0] exp_act5;
  } vec_t;

  vec_t vecs[14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;

    arst_n = 1'b0; addr = '0; wdata = '0; we = 0; safe = 0;
    model_reset();
    #1;
    check("reset_pending_async", {31'b0, pending}, 32'd0);
    repeat (2) @(posedge clk);
    release_reset();

    // Reset state
    addr = 5'd0; #1; check("reset_id", rdata, ID);
    addr = 5'd2; #1; check("reset_status", rdata, 32'd0);
    check("reset_active", {31'b0, |active}, 32'd0);
    check("reset_pulse", {31'b0, pulse}, 32'd0);

    // Directed table: manual commit, idle-safe, auto-commit arming on a safe cycle
    vecs[0]  = '{5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0};
    vecs[1]  = '{5'd5, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{5'd1, 32'h1,        1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[3]  = '{5'd2, 32'h0,        1'b0, 1'b0, 32'h0000_0201, 1'b1, 1'b0, 32'h0};
    vecs[4]  = '{5'd1, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[5]  = '{5'd5, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF};
    vecs[6]  = '{5'd2, 32'h0,        1'b0, 1'b0, 32'h0000_0200, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[7]  = '{5'd1, 32'h2,        1'b1, 1'b1, 32'h0,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[8]  = '{5'd1, 32'h0,        1'b0, 1'b0, 32'h2,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[9]  = '{5'd6, 32'h1234,     1'b1, 1'b1, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    vecs[10] = '{5'd6, 32'h0,        1'b0, 1'b1, 32'h1234,     1'b0, 1'b0, 32'hDEADBEEF};
    vecs[11] = '{5'd6, 32'h0,        1'b0, 1'b0, 32'h1234,     1'b0, 1'b1, 32'hDEADBEEF};
    vecs[12] = '{5'd1, 32'h0,        1'b1, 1'b0, 32'h2,        1'b0, 1'b0, 32'hDEADBEEF};
    vecs[13] = '{5'd2, 32'h0,        1'b0, 1'b0, 32'h0000_0500, 1'b0, 1'b0, 32'hDEADBEEF};

    for (int v = 0; v < 14; v++) begin
      tick(int'(vecs[v].addr), vecs[v].data, vecs[v].we, vecs[v].safe, rd);
      check($sformatf("vec%0d_rd", v), rd, vecs[v].exp_rd);
      check($sformatf("vec%0d_pend", v), {31'b0, pending}, {31'b0, vecs[v].exp_pend});
      check($sformatf("vec%0d_pulse", v), {31'b0, pulse}, {31'b0, vecs[v].exp_pulse});
      check($sformatf("vec%0d_act5", v), act_reg(5), vecs[v].exp_act5);
    end
    check("vec_act6", act_reg(6), 32'h1234);

    // Auto-commit held off by a long unsafe stretch
    tick(1, 32'h2, 1, 0, rd);
    tick(3, 32'hA5A5_0003, 1, 0, rd);
    for (int k = 0; k < 100; k++) begin
      tick(3, 32'h0, 0, 0, rd);
      check("hold_pending", {31'b0, pending}, 32'd1);
      check("hold_act3", act_reg(3), 32'h0);
    end
    tick(3, 32'h0, 0, 1, rd);
    check("hold_commit_act3", act_reg(3), 32'hA5A5_0003);
    check("hold_commit_nopulse", {31'b0, pulse}, 32'd0);
    tick(3, 32'h0, 0, 0, rd);
    check("hold_pulse", {31'b0, pulse}, 32'd1);
    check("hold_pend_clear", {31'b0, pending}, 32'd0);

    // Shadow write coinciding with a commit
    tick(4, 32'h1111_AAAA, 1, 0, rd);
    tick(4, 32'h2222_BBBB, 1, 1, rd);
    check("simul_act4_old", act_reg(4), 32'h1111_AAAA);
    check("simul_still_armed", {31'b0, pending}, 32'd1);
    tick(4, 32'h0, 0, 1, rd);
    check("simul_act4_new", act_reg(4), 32'h2222_BBBB);
    tick(4, 32'h0, 0, 0, rd);
    check("simul_pulse", {31'b0, pulse}, 32'd1);

    // Read-only error counting and write_count wrap, from a fresh reset
    arst_n = 1'b0; model_reset(); #1;
    release_reset();
    for (int k = 0; k < 3; k++) tick(0, $urandom, 1, 0, rd);
    for (int k = 0; k < 3; k++) tick(2, $urandom, 1, 0, rd);
    tick(2, 32'h0, 0, 0, rd); check("ro_status", rd, 32'h0006_0000);
    tick(0, 32'h0, 0, 0, rd); check("ro_id", rd, ID);
    for (int k = 0; k < 255; k++) tick(10, 32'(k), 1, 0, rd);
    tick(2, 32'h0, 0, 0, rd); check("wc_255", rd, 32'h0006_FF00);
    tick(10, 32'hFFFF_0000, 1, 0, rd);
    tick(2, 32'h0, 0, 0, rd); check("wc_wrap", rd, 32'h0006_0000);

    // Reset asserted mid-cycle while armed
    tick(9, 32'h55, 1, 0, rd);
    tick(1, 32'h1, 1, 0, rd);
    check("pre_rst_armed", {31'b0, pending}, 32'd1);
    #3;
    arst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_pending", {31'b0, pending}, 32'd0);
    check("async_rst_pulse", {31'b0, pulse}, 32'd0);
    check("async_rst_active", {31'b0, |active}, 32'd0);
    addr = 5'd9; #1; check("async_rst_shadow9", rdata, 32'd0);
    release_reset();
    tick(9, 32'h0, 0, 1, rd);
    check("post_rst_act9", act_reg(9), 32'd0);
    tick(9, 32'h0, 0, 0, rd);
    check("post_rst_nopulse", {31'b0, pulse}, 32'd0);

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      int a;
      logic [31:0] d;
      a = $urandom_range(0, 31);
      if ($urandom_range(0, 7) == 0) a = 1;
      d = $urandom;
      tick(a, d, $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, rd);
    end
    tick(2, 32'h0, 0, 0, rd);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
